// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB configuration loader.
//   - cfg_state_e : loader FSM states
//   - CLB cfg bus layout constants (LUT / DFF / OMUX / carry-chain fields)
//   - cfg_nwords(): number of WORD_W words needed to cover CFG_SIZE bits
package clb_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_HOLD   = 3'd3,
        ST_RUN    = 3'd4,
        ST_ERR    = 3'd5
    } cfg_state_e;

    // CLB cfg bus layout: two LUT tables, then DFF, output-mux and carry-chain fields.
    localparam int unsigned CFG_LUT_SIZE  = 33;
    localparam int unsigned CFG_LUT_OFS   = 0;
    localparam int unsigned CFG_DFF_OFS   = 2 * CFG_LUT_SIZE;
    localparam int unsigned CFG_DFF_SIZE  = 4;
    localparam int unsigned CFG_OMUX_OFS  = CFG_DFF_OFS + CFG_DFF_SIZE;
    localparam int unsigned CFG_OMUX_SIZE = 4;
    localparam int unsigned CFG_CC_OFS    = CFG_OMUX_OFS + CFG_OMUX_SIZE;
    localparam int unsigned CFG_CC_SIZE   = 2;

    // Width of the post-commit fabric reset counter (RST_CYCLES is 1..15).
    localparam int unsigned HOLD_W = 4;

    function automatic int unsigned cfg_nwords(input int unsigned cfg_size,
                                               input int unsigned word_w);
        return (cfg_size + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/clb_cfg_shadow.sv
// Shadow register for one CLB configuration, written one word at a time.
//   clk, crst_n : clock, async active-low reset (clears the shadow)
//   clr_i       : synchronous clear of the whole shadow
//   we_i, idx_i : write wdata_i into word slot idx_i
//   wdata_i     : configuration word
//   data_o      : full-width shadow contents
module clb_cfg_shadow
    import clb_cfg_pkg::*;
#(
    parameter int unsigned CFG_SIZE = 256,
    parameter int unsigned WORD_W   = 32,
    parameter int unsigned NWORDS   = 8,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                clk,
    input  logic                crst_n,
    input  logic                clr_i,
    input  logic                we_i,
    input  logic [IDX_W-1:0]    idx_i,
    input  logic [WORD_W-1:0]   wdata_i,
    output logic [CFG_SIZE-1:0] data_o
);

    // One register per word slot; the last slot is narrowed so bits beyond CFG_SIZE are never stored.
    for (genvar k = 0; k < NWORDS; k++) begin : g_word
        localparam int unsigned LO = k * WORD_W;
        localparam int unsigned WK = ((CFG_SIZE - LO) < WORD_W) ? (CFG_SIZE - LO) : WORD_W;

        logic [WK-1:0] word_q;

        always_ff @(posedge clk or negedge crst_n) begin
            if (!crst_n) begin
                word_q <= '0;
            end else if (clr_i) begin
                word_q <= '0;
            end else if (we_i && (idx_i == IDX_W'(k))) begin
                word_q <= wdata_i[WK-1:0];
            end
        end

        assign data_o[LO +: WK] = word_q;
    end

endmodule

// File: rtl/clb_cfg_loader.sv
// Configuration controller for one CLB tile: collects a word stream into a
// shadow register, commits it atomically to cfg_o and sequences fab_rst/fab_ce.
//   clk, crst_n        : clock, async active-low reset
//   start, abort       : single-cycle control pulses
//   s_valid/s_ready    : word handshake; s_data word k -> cfg bits [k*WORD_W +: WORD_W]
//   s_last             : marks final word of a load
//   cfg_o              : committed configuration to the CLB
//   fab_rst, fab_ce    : CLB reset (active high) and clock enable
//   busy, done, err    : status (busy outside IDLE/RUN/ERR, done in RUN, err in ERR)
//   word_cnt           : words accepted in the current load
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter  int unsigned CFG_SIZE   = 256,
    parameter  int unsigned WORD_W     = 32,
    parameter  int unsigned RST_CYCLES = 2,
    localparam int unsigned NWORDS     = cfg_nwords(CFG_SIZE, WORD_W),
    localparam int unsigned CNT_W      = $clog2(NWORDS + 1)
) (
    input  logic                clk,
    input  logic                crst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [WORD_W-1:0]   s_data,
    input  logic                s_last,
    output logic [CFG_SIZE-1:0] cfg_o,
    output logic                fab_rst,
    output logic                fab_ce,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    word_cnt
);

    cfg_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [CFG_SIZE-1:0] cfg_q, cfg_d;
    logic                s_ready_q, s_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                fab_rst_q, fab_rst_d;
    logic                fab_ce_q, fab_ce_d;

    logic                shadow_clr;
    logic                shadow_we;
    logic [CFG_SIZE-1:0] shadow;
    logic                accept;
    logic                last_idx;

    clb_cfg_shadow #(
        .CFG_SIZE (CFG_SIZE),
        .WORD_W   (WORD_W),
        .NWORDS   (NWORDS),
        .IDX_W    (CNT_W)
    ) u_shadow (
        .clk     (clk),
        .crst_n  (crst_n),
        .clr_i   (shadow_clr),
        .we_i    (shadow_we),
        .idx_i   (cnt_q),
        .wdata_i (s_data),
        .data_o  (shadow)
    );

    // s_ready_q is only ever high in LOAD, so it doubles as the acceptance qualifier.
    assign accept   = s_valid && s_ready_q;
    assign last_idx = (cnt_q == CNT_W'(NWORDS - 1));

    // State and output registers.
    always_ff @(posedge clk or negedge crst_n) begin
        if (!crst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hold_q    <= '0;
            cfg_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fab_rst_q <= 1'b1;
            fab_ce_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
            cfg_q     <= cfg_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            fab_rst_q <= fab_rst_d;
            fab_ce_q  <= fab_ce_d;
        end
    end

    // Next-state, datapath controls and next output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        cfg_d      = cfg_q;
        shadow_clr = 1'b0;
        shadow_we  = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    cnt_d      = '0;
                    shadow_clr = 1'b1;
                end
            end
            ST_LOAD: begin
                // abort has priority over a word arriving in the same cycle
                if (abort) begin
                    state_d = ST_ERR;
                end else if (accept) begin
                    shadow_we = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (last_idx) begin
                        state_d = s_last ? ST_COMMIT : ST_ERR;
                    end else if (s_last) begin
                        state_d = ST_ERR;
                    end
                end
            end
            ST_COMMIT: begin
                cfg_d   = shadow;
                hold_d  = HOLD_W'(RST_CYCLES);
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (hold_q <= HOLD_W'(1)) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        s_ready_d = (state_d == ST_LOAD);
        busy_d    = !((state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_ERR));
        done_d    = (state_d == ST_RUN);
        err_d     = (state_d == ST_ERR);
        // Fabric controls follow the current state, so they switch one edge after a state change.
        fab_rst_d = (state_q != ST_RUN);
        fab_ce_d  = (state_q == ST_RUN);
    end

    assign s_ready  = s_ready_q;
    assign cfg_o    = cfg_q;
    assign fab_rst  = fab_rst_q;
    assign fab_ce   = fab_ce_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed self-checking bench for clb_cfg_loader (256-bit and 150-bit instances).
module tb_clb_cfg_loader;

    logic clk    = 1'b0;
    logic crst_n = 1'b0;

    always #5 clk = ~clk;

    // 256-bit instance
    logic         start = 1'b0, abort = 1'b0, s_valid = 1'b0, s_last = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_ready, fab_rst, fab_ce, busy, done, err;
    logic [255:0] cfg_o;
    logic [3:0]   word_cnt;

    // 150-bit instance
    logic         b_start = 1'b0, b_abort = 1'b0, b_valid = 1'b0, b_last = 1'b0;
    logic [31:0]  b_data = '0;
    logic         b_ready, b_fab_rst, b_fab_ce, b_busy, b_done, b_err;
    logic [149:0] b_cfg;
    logic [2:0]   b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [255:0] NOMINAL =
        256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
    localparam logic [149:0] EXP150 =
        {22'h3FFFFF, 128'h44444444_33333333_22222222_11111111};

    clb_cfg_loader #(.CFG_SIZE(256), .WORD_W(32), .RST_CYCLES(2)) u_dut (
        .clk(clk), .crst_n(crst_n), .start(start), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .cfg_o(cfg_o), .fab_rst(fab_rst), .fab_ce(fab_ce), .busy(busy),
        .done(done), .err(err), .word_cnt(word_cnt)
    );

    clb_cfg_loader #(.CFG_SIZE(150), .WORD_W(32), .RST_CYCLES(2)) u_dut150 (
        .clk(clk), .crst_n(crst_n), .start(b_start), .abort(b_abort),
        .s_valid(b_valid), .s_ready(b_ready), .s_data(b_data), .s_last(b_last),
        .cfg_o(b_cfg), .fab_rst(b_fab_rst), .fab_ce(b_fab_ce), .busy(b_busy),
        .done(b_done), .err(b_err), .word_cnt(b_cnt)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Word i (1-based) is 0x11111111*i ^ mask; s_last on word last_pos (0 = never).
    task automatic load_words(input int n, input int last_pos, input logic [31:0] mask);
        for (int i = 1; i <= n; i++) begin
            s_valid = 1'b1;
            s_data  = (32'h11111111 * 32'(i)) ^ mask;
            s_last  = (i == last_pos);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    function automatic logic [255:0] exp_cfg(input logic [31:0] mask);
        logic [255:0] r;
        for (int k = 0; k < 8; k++) begin
            r[k*32 +: 32] = (32'h11111111 * 32'(k + 1)) ^ mask;
        end
        return r;
    endfunction

    initial begin
        logic [255:0] exp_rec;
        exp_rec = exp_cfg(32'hFFFF0000);

        // Reset values
        #12;
        check("rst_cfg",     cfg_o,             256'(0));
        check("rst_fab_rst", 256'(fab_rst),     256'(1));
        check("rst_fab_ce",  256'(fab_ce),      256'(0));
        check("rst_ready",   256'(s_ready),     256'(0));
        check("rst_status",  256'({busy, done, err}), 256'(0));
        check("rst_cnt",     256'(word_cnt),    256'(0));
        #10 crst_n = 1'b1;
        tick();

        // Nominal load
        do_start();
        check("nom_ready",   256'(s_ready),     256'(1));
        check("nom_busy",    256'(busy),        256'(1));
        load_words(8, 8, 32'h0);
        check("nom_cfg_pre", cfg_o,             256'(0));
        check("nom_cnt",     256'(word_cnt),    256'(8));
        check("nom_rdy_off", 256'(s_ready),     256'(0));
        tick();
        check("nom_cfg",     cfg_o,             NOMINAL);
        check("nom_rst_c0",  256'(fab_rst),     256'(1));
        tick();
        check("nom_rst_c1",  256'(fab_rst),     256'(1));
        tick();
        check("nom_rst_c2",  256'(fab_rst),     256'(1));
        check("nom_ce_c2",   256'(fab_ce),      256'(0));
        tick();
        check("nom_ce",      256'(fab_ce),      256'(1));
        check("nom_rst_off", 256'(fab_rst),     256'(0));
        check("nom_done",    256'(done),        256'(1));
        check("nom_busy_off",256'(busy),        256'(0));

        // Short load: s_last on 5th word
        do_start();
        load_words(5, 5, 32'h0);
        check("short_err",   256'(err),         256'(1));
        check("short_cnt",   256'(word_cnt),    256'(5));
        check("short_cfg",   cfg_o,             NOMINAL);
        check("short_ce",    256'(fab_ce),      256'(0));
        check("short_rst",   256'(fab_rst),     256'(1));
        check("short_done",  256'(done),        256'(0));

        // Long load: 8th word without s_last, then a 9th offered
        do_start();
        check("long_err_clr",256'(err),         256'(0));
        check("long_ready",  256'(s_ready),     256'(1));
        load_words(8, 0, 32'h0);
        check("long_err",    256'(err),         256'(1));
        check("long_ready0", 256'(s_ready),     256'(0));
        s_valid = 1'b1;
        s_data  = 32'h99999999;
        tick();
        s_valid = 1'b0;
        check("long_cnt9",   256'(word_cnt),    256'(8));
        check("long_cfg",    cfg_o,             NOMINAL);

        // Abort together with the 3rd word, then recover
        do_start();
        load_words(2, 0, 32'h0);
        s_valid = 1'b1;
        s_data  = 32'h33333333;
        abort   = 1'b1;
        tick();
        s_valid = 1'b0;
        abort   = 1'b0;
        check("abort_err",   256'(err),         256'(1));
        check("abort_cnt",   256'(word_cnt),    256'(2));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_in_err",256'(err),         256'(1));
        do_start();
        load_words(8, 8, 32'hFFFF0000);
        tick();
        check("rec_cfg",     cfg_o,             exp_rec);
        tick(); tick(); tick();
        check("rec_done",    256'(done),        256'(1));
        check("rec_ce",      256'(fab_ce),      256'(1));

        // Reset pulse during HOLD
        do_start();
        load_words(8, 8, 32'h0);
        tick();
        check("hold_cfg",    cfg_o,             NOMINAL);
        check("hold_busy",   256'(busy),        256'(1));
        #1 crst_n = 1'b0;
        #1;
        check("arst_cfg",    cfg_o,             256'(0));
        check("arst_fab",    256'({fab_rst, fab_ce}), 256'(2));
        check("arst_busy",   256'(busy),        256'(0));
        #1 crst_n = 1'b1;
        tick();
        s_valid = 1'b1;
        s_data  = 32'hDEADBEEF;
        tick(); tick();
        s_valid = 1'b0;
        check("post_ready",  256'(s_ready),     256'(0));
        check("post_cnt",    256'(word_cnt),    256'(0));
        check("post_status", 256'({busy, done, err}), 256'(0));
        check("post_fab",    256'({fab_rst, fab_ce}), 256'(2));

        // 150-bit instance: last word truncated
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            b_valid = 1'b1;
            b_data  = (i == 5) ? 32'hFFFFFFFF : (32'h11111111 * 32'(i));
            b_last  = (i == 5);
            tick();
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
        check("b150_cnt",    256'(b_cnt),       256'(5));
        tick();
        check("b150_top",    256'(b_cfg[149:128]), 256'(22'h3FFFFF));
        check("b150_cfg",    256'(b_cfg),       256'(EXP150));
        tick(); tick(); tick();
        check("b150_done",   256'({b_done, b_fab_ce, b_err}), 256'(6));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
